// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: word width, block derivations and
// the FSM state encoding used by the serial subtractor.
package arith_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of blocks one word splits into.
  function automatic int num_blocks(input int block_size);
    return WORD_W / block_size;
  endfunction

  // Counter wide enough to hold 0..nb (bypass count).
  function automatic int cnt_width(input int nb);
    return $clog2(nb + 1);
  endfunction

  // Block index width; a single-block configuration still needs one bit.
  function automatic int idx_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/borrow_ripple_block.sv
// Combinational WIDTH-bit ripple-borrow subtractor: diff = a - b - bin.
module borrow_ripple_block #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Bit-serial borrow chain through the block.
  always_comb begin
    logic br;
    br   = bin;
    diff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ br;
      br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/block_serial_subtractor.sv
// Multi-cycle 32-bit subtractor: one BLOCK_SIZE-bit block per clock, LSB
// block first, with borrow-bypass when a block's operands are equal.
import arith_pkg::*;

module block_serial_subtractor #(
  parameter  int BLOCK_SIZE = 4,
  localparam int NUM_BLOCKS = num_blocks(BLOCK_SIZE),
  localparam int CNT_W      = cnt_width(NUM_BLOCKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] diff,
  output logic              bout,
  output logic              overflow,
  output logic [CNT_W-1:0]  bypass_cnt
);

  localparam int IDX_W = idx_width(NUM_BLOCKS);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] a_q, b_q, diff_q;
  logic              borrow_q, bout_q, ovf_q;
  logic [IDX_W-1:0]  blk_idx_q;
  logic [CNT_W-1:0]  bypass_q;

  int unsigned           blk_off;
  logic [BLOCK_SIZE-1:0] a_blk, b_blk, d_blk;
  logic                  rip_bout, prop, borrow_nxt, last_blk, accept;

  assign blk_off  = 32'(blk_idx_q) * BLOCK_SIZE;
  assign a_blk    = a_q[blk_off +: BLOCK_SIZE];
  assign b_blk    = b_q[blk_off +: BLOCK_SIZE];
  assign last_blk = (blk_idx_q == IDX_W'(NUM_BLOCKS - 1));
  assign accept   = (state_q == ST_IDLE) && in_valid;

  borrow_ripple_block #(.WIDTH(BLOCK_SIZE)) u_blk (
    .a    (a_blk),
    .b    (b_blk),
    .bin  (borrow_q),
    .diff (d_blk),
    .bout (rip_bout)
  );

  // Bypass mux: equal operands pass the incoming borrow straight through.
  assign prop       = &(a_blk ~^ b_blk);
  assign borrow_nxt = prop ? borrow_q : rip_bout;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_blk)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept, then one block retired per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      blk_idx_q <= '0;
      bypass_q  <= '0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      borrow_q  <= bin;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      blk_idx_q <= '0;
      bypass_q  <= '0;
    end else if (state_q == ST_RUN) begin
      diff_q[blk_off +: BLOCK_SIZE] <= d_blk;
      borrow_q  <= borrow_nxt;
      blk_idx_q <= blk_idx_q + IDX_W'(1);
      if (prop) bypass_q <= bypass_q + CNT_W'(1);
      // Final block: d_blk's MSB is diff[31], so overflow resolves here.
      if (last_blk) begin
        bout_q <= borrow_nxt;
        ovf_q  <= (a_q[WORD_W-1] & ~b_q[WORD_W-1] & ~d_blk[BLOCK_SIZE-1]) |
                  (~a_q[WORD_W-1] & b_q[WORD_W-1] &  d_blk[BLOCK_SIZE-1]);
      end
    end
  end

  assign diff       = diff_q;
  assign bout       = bout_q;
  assign overflow   = ovf_q;
  assign bypass_cnt = bypass_q;

endmodule
